bus_arbiter_rr: RTL and testbench
=================================

# bus_arbiter_rr

Round-robin arbiter and bus watchdog for the shared system bus. It arbitrates up to eight DMA-style request lines from bus masters (the CPU instruction and data ports, plus future DMA engines) and issues a one-hot grant. It drives `BUS_req` toward the slaves (RAM, UART, timer) and enforces a per-master tenure limit. It detects slaves that never return `BUS_ready` and reports the offending master.

## Interface
Parameters:
- `N`, 8: number of requesters; `grant`/`DMA` width.
- `MAX_HOLD`, 16: tenure limit in cycles before preemption is allowed.
- `TIMEOUT`, 255: cycles without `BUS_ready` before a bus error; 0 disables the watchdog.
- `TO_W`, 8: watchdog counter width; must hold `TIMEOUT`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr_in`  in  1  reset; asynchronous, active-low.
- `DMA`  in  N  request lines; bit i high means master i wants the bus or is still using it.
- `BUS_ready`  in  1  slave completion strobe; one cycle per finished transfer.
- `err_clr`  in  1  clears `err_sticky`.
- `grant`  out  N  one-hot registered grant; all-zero means the bus is idle.
- `BUS_req`  out  1  registered; high exactly when `grant` is nonzero.
- `owner`  out  3  index of the current or most recent grantee.
- `bus_err`  out  1  one-cycle pulse on watchdog timeout.
- `err_master`  out  3  index of the master that timed out; holds until the next error.
- `err_sticky`  out  1  set by `bus_err`; cleared by `err_clr`.

## Operation
- States are IDLE, GRANT and TURN. Registers are `ptr` (round-robin start), `hold_cnt` and `wd_cnt`.
- **IDLE or TURN:**
  - If `DMA` is nonzero, select the first set bit scanning from `ptr` upward, with wrap-around modulo N.
  - Load `grant`, `owner` and `BUS_req`, clear both counters, and go to GRANT.
  - If `DMA` is zero, go to or stay in IDLE.
  - TURN always lasts exactly one cycle with `grant` = 0.
- **GRANT** checks exit conditions in this priority order:
  1. `DMA[owner]` = 0: release.
  2. `TIMEOUT` != 0 and `wd_cnt` == `TIMEOUT`-1 with no `BUS_ready` this cycle:
     - Release.
     - Pulse `bus_err`, set `err_sticky`, and load `err_master` = `owner`.
  3. `BUS_ready` = 1, `hold_cnt` >= `MAX_HOLD`-1, and another `DMA` bit is set: release (preempt).
  - Release means: `grant` and `BUS_req` go to 0, `ptr` = `owner`+1 mod N, go to TURN.
  - If no exit fires, stay in GRANT.
- **Counters:**
  - `hold_cnt` increments every GRANT cycle and saturates.
  - `wd_cnt` clears on `BUS_ready` and otherwise increments.
- A preempted or timed-out master that keeps `DMA` high is treated as an ordinary requester. Because `ptr` has already moved past it, it is served last.
- If `err_clr` and `bus_err` occur in the same cycle, the error wins and `err_sticky` stays at 1.

## Timing
- Reset (`clr_in` low, asynchronous) sets:
  - `grant` = 0, `BUS_req` = 0, `owner` = 0.
  - `bus_err` = 0, `err_master` = 0, `err_sticky` = 0.
  - `ptr` = 0, state IDLE.
- Reset applied mid-tenure drops the grant immediately, with no TURN cycle.
- Grant latency from IDLE: `DMA` sampled high at edge k gives `grant` high after edge k.
- Handoff: `DMA[owner]` sampled low at edge k gives `grant` = 0 after k and the new grant after k+1. There is exactly one dead cycle.
- `bus_err` is high for the single cycle following the timeout edge, coincident with the TURN cycle.
- With `TIMEOUT` = T and no `BUS_ready`, `grant` drops T cycles after it was asserted.
- `grant` is never multi-hot, and it is never nonzero during TURN.

## Test plan
- **Reset:** hold `clr_in` low with `DMA`=8'hFF, then release → `grant`=8'h01 one cycle after the first edge; all error outputs stay 0.
- **Round-robin:**
  - `DMA`=8'h0B held; each master drops its request after 3 cycles and re-raises it.
  - → grant order 01, 02, 08, 01, …, with one zero cycle between grants.
- **Preemption:**
  - Master 0 holds `DMA` with `BUS_ready` every cycle; master 5 requests at cycle 2.
  - → `grant` moves to 8'h20 after a TURN cycle, at cycle `MAX_HOLD`+1 of master 0's tenure.
- **Watchdog:**
  - `TIMEOUT`=255; master 3 granted; `BUS_ready` never asserted.
  - → after 255 cycles: `bus_err` pulses once, `err_master`=3, `err_sticky`=1, `grant`=0.
  - Asserting `err_clr` then clears the sticky bit.
- **Simultaneous events:**
  - `DMA[owner]` drops on the same cycle the watchdog expires → normal release, no `bus_err`.
  - `err_clr` coincident with a new error → `err_sticky` stays 1.
- **Async reset mid-tenure:** pulse `clr_in` low between clock edges while `grant`=8'h04 → `grant` and `BUS_req` go to 0 without waiting for a clock edge; arbitration restarts from `ptr`=0.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with tenure preemption and slave watchdog; grant is registered, one cycle after DMA is sampled.
// No backpressure: requesters hold DMA until served, and each handoff inserts one dead (TURN) cycle.
module bus_arbiter_rr #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          clr_in,
    input  logic [N-1:0]  DMA,
    input  logic          BUS_ready,
    input  logic          err_clr,
    output logic [N-1:0]  grant,
    output logic          BUS_req,
    output logic [IW-1:0] owner,
    output logic          bus_err,
    output logic [IW-1:0] err_master,
    output logic          err_sticky
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    localparam int              HW        = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0]   HOLD_SAT  = '1;
    localparam logic            TO_EN     = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            req_q, req_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            err_q, err_d;
    logic [IW-1:0]   errm_q, errm_d;
    logic            sticky_q, sticky_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   ptr_inc;
    logic            others_req;
    logic            rel;

    // Scan downward so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (DMA[(int'(ptr_q) + k) % N]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    assign ptr_inc    = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
    assign others_req = |(DMA & ~grant_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        wd_d    = wd_q;
        grant_d = grant_q;
        owner_d = owner_q;
        err_d   = 1'b0;
        errm_d  = errm_q;
        rel     = 1'b0;

        case (state_q)
            ST_GRANT: begin
                if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
                wd_d = BUS_ready ? '0 : wd_q + 1'b1;

                if (!DMA[owner_q]) begin
                    rel = 1'b1;
                end else if (TO_EN && (wd_q == TO_LAST) && !BUS_ready) begin
                    rel    = 1'b1;
                    err_d  = 1'b1;
                    errm_d = owner_q;
                end else if (BUS_ready && (hold_q >= HOLD_LAST) && others_req) begin
                    rel = 1'b1;
                end

                if (rel) begin
                    grant_d = '0;
                    ptr_d   = ptr_inc;
                    state_d = ST_TURN;
                end
            end
            default: begin
                if (pick_vld) begin
                    grant_d = N'(1) << pick_idx;
                    owner_d = pick_idx;
                    hold_d  = '0;
                    wd_d    = '0;
                    state_d = ST_GRANT;
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase

        req_d = |grant_d;
        // A new error outranks a coincident clear.
        sticky_d = err_d ? 1'b1 : (err_clr ? 1'b0 : sticky_q);
    end

    always_ff @(posedge clk or negedge clr_in) begin
        if (!clr_in) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            hold_q   <= '0;
            wd_q     <= '0;
            grant_q  <= '0;
            req_q    <= 1'b0;
            owner_q  <= '0;
            err_q    <= 1'b0;
            errm_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            wd_q     <= wd_d;
            grant_q  <= grant_d;
            req_q    <= req_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
            errm_q   <= errm_d;
            sticky_q <= sticky_d;
        end
    end

    assign grant      = grant_q;
    assign BUS_req    = req_q;
    assign owner      = owner_q;
    assign bus_err    = err_q;
    assign err_master = errm_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: tenure-level reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_bus_arbiter_rr;

    localparam int N  = 8;
    localparam int MH = 16;
    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       clr_in = 1'b1;
    logic [7:0] DMA = 8'h00;
    logic       BUS_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] grant;
    logic       BUS_req;
    logic [2:0] owner;
    logic       bus_err;
    logic [2:0] err_master;
    logic       err_sticky;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(.N(N), .MAX_HOLD(MH), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .clr_in(clr_in), .DMA(DMA), .BUS_ready(BUS_ready), .err_clr(err_clr),
        .grant(grant), .BUS_req(BUS_req), .owner(owner), .bus_err(bus_err),
        .err_master(err_master), .err_sticky(err_sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks who holds the bus, how long the tenure has run
    // and how many consecutive granted cycles passed without BUS_ready.
    int m_owner = 0, m_ptr = 0, m_tenure = 0, m_quiet = 0, m_errm = 0;
    bit m_active = 0, m_err = 0, m_sticky = 0;

    always @(posedge clk or negedge clr_in) begin
        if (!clr_in) begin
            m_owner = 0; m_ptr = 0; m_tenure = 0; m_quiet = 0; m_errm = 0;
            m_active = 0; m_err = 0; m_sticky = 0;
        end else begin
            bit rel, e, found;
            rel = 0; e = 0; found = 0;
            if (m_active) begin
                m_tenure++;
                m_quiet = BUS_ready ? 0 : m_quiet + 1;
                if (!DMA[m_owner]) rel = 1;
                else if (TO != 0 && !BUS_ready && m_quiet == TO) begin rel = 1; e = 1; end
                else if (BUS_ready && m_tenure >= MH && (DMA & ~(8'd1 << m_owner)) != 0) rel = 1;
                if (rel) begin
                    m_active = 0;
                    m_ptr = (m_owner + 1) % N;
                end
            end else if (DMA != 0) begin
                for (int off = 0; off < N; off++) begin
                    if (!found && DMA[(m_ptr + off) % N]) begin
                        m_owner = (m_ptr + off) % N;
                        found = 1;
                    end
                end
                m_active = 1; m_tenure = 0; m_quiet = 0;
            end
            m_err = e;
            if (e) begin m_errm = m_owner; m_sticky = 1; end
            else if (err_clr) m_sticky = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [7:0] eg;
            eg = m_active ? 8'(1 << m_owner) : 8'h00;
            chk("model_grant", grant, eg);
            chk("model_bus_req", BUS_req, m_active);
            chk("model_owner", owner, m_owner);
            chk("model_bus_err", bus_err, m_err);
            chk("model_err_master", err_master, m_errm);
            chk("model_err_sticky", err_sticky, m_sticky);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 clr_in = 1'b0;
        DMA = 8'h00; BUS_ready = 1'b0; err_clr = 1'b0;
        #2 clr_in = 1'b1;
    endtask

    task automatic wait_grant(input logic [7:0] g, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (grant === g) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_grant actual=%0h required=%0h", grant, g);
        end
    endtask

    initial begin
        logic [7:0] seq [6];
        logic [7:0] exp_rr [6];
        logic [7:0] prev;
        int nseq, run, cnt;
        bit done;

        // Reset held with all masters requesting
        #1 clr_in = 1'b0;
        chk_on = 1'b1;
        DMA = 8'hFF;
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 8'h00);
        chk("rst_bus_req", BUS_req, 1'b0);
        chk("rst_owner", owner, 3'd0);
        chk("rst_err", {bus_err, err_master, err_sticky}, 5'd0);
        #1 clr_in = 1'b1;
        @(negedge clk);
        chk("first_grant", grant, 8'h01);
        repeat (3) @(negedge clk);
        DMA = 8'h00;
        repeat (3) @(negedge clk);
        chk("no_err_after_rst", {bus_err, err_sticky}, 2'd0);

        // Round robin over masters 0,1,3, each releasing after three cycles
        do_reset();
        DMA = 8'h0B;
        exp_rr = '{8'h01, 8'h02, 8'h08, 8'h01, 8'h02, 8'h08};
        nseq = 0; run = 0; prev = 8'h00;
        for (int c = 0; c < 60 && nseq < 6; c++) begin
            @(negedge clk);
            if (grant != 8'h00 && grant != prev) begin
                seq[nseq] = grant;
                nseq++;
            end
            prev = grant;
            if (grant != 8'h00) begin
                run++;
                if (run == 3) DMA = 8'h0B & ~grant;
            end else begin
                run = 0;
                DMA = 8'h0B;
            end
        end
        chk("rr_count", nseq, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), seq[i], exp_rr[i]);
        DMA = 8'h00;
        repeat (3) @(negedge clk);

        // Preemption of master 0 by master 5
        do_reset();
        DMA = 8'h01; BUS_ready = 1'b1;
        cnt = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (grant == 8'h01) begin
                cnt++;
                if (cnt == 2) DMA = 8'h21;
            end else if (cnt > 0) done = 1;
        end
        chk("preempt_tenure", cnt, MH);
        chk("preempt_turn", grant, 8'h00);
        @(negedge clk);
        chk("preempt_new", grant, 8'h20);
        DMA = 8'h00; BUS_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Watchdog on master 3
        do_reset();
        DMA = 8'h08;
        cnt = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (grant == 8'h08) cnt++;
            else if (cnt > 0) done = 1;
        end
        chk("wd_tenure", cnt, 255);
        chk("wd_bus_err", bus_err, 1'b1);
        chk("wd_err_master", err_master, 3'd3);
        chk("wd_sticky", err_sticky, 1'b1);
        chk("wd_grant", grant, 8'h00);
        DMA = 8'h00;
        @(negedge clk);
        chk("wd_pulse_once", bus_err, 1'b0);
        chk("wd_sticky_hold", err_sticky, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("wd_sticky_clr", err_sticky, 1'b0);

        // Request drop on the expiry edge wins over the watchdog
        DMA = 8'h08;
        cnt = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (grant == 8'h08) cnt++;
            if (cnt == 255) begin DMA = 8'h00; done = 1; end
        end
        @(negedge clk);
        chk("drop_vs_wd_grant", grant, 8'h00);
        chk("drop_vs_wd_err", {bus_err, err_sticky}, 2'd0);

        // err_clr coincident with a new error
        DMA = 8'h08;
        cnt = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (grant == 8'h08) cnt++;
            if (cnt == 255) begin err_clr = 1'b1; done = 1; end
        end
        @(negedge clk);
        err_clr = 1'b0; DMA = 8'h00;
        chk("clr_vs_err_pulse", bus_err, 1'b1);
        chk("clr_vs_err_sticky", err_sticky, 1'b1);
        @(negedge clk);

        // Asynchronous reset in the middle of master 2's tenure
        do_reset();
        DMA = 8'h04;
        wait_grant(8'h04, 5);
        DMA = 8'h84;
        @(negedge clk);
        #1 clr_in = 1'b0;
        #1;
        chk("async_grant", grant, 8'h00);
        chk("async_bus_req", BUS_req, 1'b0);
        #1 clr_in = 1'b1;
        @(negedge clk);
        chk("restart_ptr0", grant, 8'h04);
        DMA = 8'h00;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
